// File: rtl/vga_timing_gen_if.sv
// Video timing bundle between the sync generator and the pixel consumer.
// The generator side uses the master modport; the consumer drives pix_en.
interface vga_timing_gen_if #(
  parameter int CW = 11
);
  logic          pix_en;
  logic          HS;
  logic          VS;
  logic          blank_n;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          line_start;
  logic          frame_start;

  modport master (
    input  pix_en,
    output HS, VS, blank_n, x, y, line_start, frame_start
  );

  modport slave (
    output pix_en,
    input  HS, VS, blank_n, x, y, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA sync/blank/coordinate generator: a pixel counter and a line counter
// advanced by pix_en, with all video outputs registered one pix_en behind them.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 11
) (
  input  logic             vga_clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_timing
    $error("vga_timing_gen: every timing parameter must be at least 1");
  end
  if (H_TOTAL - 1 >= 2 ** CW || V_TOTAL - 1 >= 2 ** CW) begin : g_bad_cw
    $error("vga_timing_gen: CW too narrow for H_TOTAL-1 / V_TOTAL-1");
  end

  localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST      = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYNC_END  = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_END  = CW'(V_SYNC);
  localparam logic [CW-1:0] H_VIS_START = CW'(H_SYNC + H_BACK);
  localparam logic [CW-1:0] V_VIS_START = CW'(V_SYNC + V_BACK);
  localparam logic [CW-1:0] H_VIS_END   = CW'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [CW-1:0] V_VIS_END   = CW'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic          HS_ON       = (HS_POL != 0);
  localparam logic          VS_ON       = (VS_POL != 0);

  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          blank_n_q, blank_n_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  logic h_wrap, v_wrap, h_vis, v_vis;

  assign h_wrap = (h_cnt_q == H_LAST);
  assign v_wrap = (v_cnt_q == V_LAST);
  assign h_vis  = (h_cnt_q >= H_VIS_START) && (h_cnt_q < H_VIS_END);
  assign v_vis  = (v_cnt_q >= V_VIS_START) && (v_cnt_q < V_VIS_END);

  always_comb begin
    // NOTE: every next-state value gets a hold default first so no path leaves it unassigned (no latch).
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    x_d       = x_q;
    y_d       = y_q;

    // Strobes are recomputed every clock, so they fall back to 0 when pix_en is low.
    line_start_d  = vga.pix_en && (h_cnt_q == '0);
    frame_start_d = vga.pix_en && (h_cnt_q == '0) && (v_cnt_q == '0);

    if (vga.pix_en) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
      if (h_wrap) begin
        v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
      end

      hs_d      = (h_cnt_q < H_SYNC_END) ? HS_ON : ~HS_ON;
      vs_d      = (v_cnt_q < V_SYNC_END) ? VS_ON : ~VS_ON;
      blank_n_d = h_vis && v_vis;
      x_d       = (h_vis && v_vis) ? h_cnt_q - H_VIS_START : '0;
      y_d       = (h_vis && v_vis) ? v_cnt_q - V_VIS_START : '0;
    end
  end

  always_ff @(posedge vga_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hs_q          <= ~HS_ON;
      vs_q          <= ~VS_ON;
      blank_n_q     <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.HS          = hs_q;
  assign vga.VS          = vs_q;
  assign vga.blank_n     = blank_n_q;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny 8x4 instance
// with active-high syncs, each checked every clock against a pixel-index model.
module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  logic pe0     = 1'b1;
  logic pe1     = 1'b1;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen_if #(.CW(11)) if0 ();
  vga_timing_gen_if #(.CW(11)) if1 ();

  assign if0.pix_en = pe0;
  assign if1.pix_en = pe1;

  vga_timing_gen dut0 (
    .vga_clk (vga_clk),
    .reset   (reset),
    .vga     (if0.master)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
    .V_ACTIVE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .HS_POL   (1), .VS_POL  (1), .CW     (11)
  ) dut1 (
    .vga_clk (vga_clk),
    .reset   (reset),
    .vga     (if1.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hand-derived geometry per instance: totals and the visible window bounds.
  localparam int HT  [2] = '{800, 14};
  localparam int VT  [2] = '{525, 7};
  localparam int HSY [2] = '{96, 2};
  localparam int VSY [2] = '{2, 1};
  localparam int HAS [2] = '{144, 4};
  localparam int HAE [2] = '{784, 12};
  localparam int VAS [2] = '{35, 2};
  localparam int VAE [2] = '{515, 6};
  localparam bit POL [2] = '{1'b0, 1'b1};

  int          mp [2];
  logic        m_hs [2], m_vs [2], m_bl [2], m_ls [2], m_fs [2];
  logic [10:0] m_x [2], m_y [2];
  bit          m_valid = 1'b0;
  int          mh, mv;
  bit          mpe, mvis;

  // Model: a pixel index within the frame; position is index mod/div line length.
  always @(posedge vga_clk) begin
    for (int k = 0; k < 2; k++) begin
      mpe = (k == 0) ? pe0 : pe1;
      if (reset) begin
        mp[k]   = 0;
        m_hs[k] = ~POL[k];
        m_vs[k] = ~POL[k];
        m_bl[k] = 1'b0;
        m_x[k]  = '0;
        m_y[k]  = '0;
        m_ls[k] = 1'b0;
        m_fs[k] = 1'b0;
        m_valid = 1'b1;
      end else if (m_valid) begin
        mh = mp[k] % HT[k];
        mv = mp[k] / HT[k];
        m_ls[k] = mpe && (mh == 0);
        m_fs[k] = mpe && (mh == 0) && (mv == 0);
        if (mpe) begin
          mvis    = (mh >= HAS[k]) && (mh < HAE[k]) && (mv >= VAS[k]) && (mv < VAE[k]);
          m_hs[k] = (mh < HSY[k]) ? POL[k] : ~POL[k];
          m_vs[k] = (mv < VSY[k]) ? POL[k] : ~POL[k];
          m_bl[k] = mvis;
          m_x[k]  = mvis ? 11'(mh - HAS[k]) : 11'd0;
          m_y[k]  = mvis ? 11'(mv - VAS[k]) : 11'd0;
          mp[k]   = (mp[k] + 1) % (HT[k] * VT[k]);
        end
      end
    end
  end

  logic [26:0] act0, act1;
  assign act0 = {if0.HS, if0.VS, if0.blank_n, if0.x, if0.y, if0.line_start, if0.frame_start};
  assign act1 = {if1.HS, if1.VS, if1.blank_n, if1.x, if1.y, if1.line_start, if1.frame_start};

  always @(negedge vga_clk) begin
    if (m_valid) begin
      check("dut0_cycle", {5'd0, act0},
            {5'd0, m_hs[0], m_vs[0], m_bl[0], m_x[0], m_y[0], m_ls[0], m_fs[0]});
      check("dut1_cycle", {5'd0, act1},
            {5'd0, m_hs[1], m_vs[1], m_bl[1], m_x[1], m_y[1], m_ls[1], m_fs[1]});
    end
  end

  int n_hs0_low = 0, n_vs0_low = 0, second_ls0 = -1, first_bl0 = -1, bl_x0 = -1, bl_y0 = -1;
  int n_hs1_hi = 0, n_vs1_hi = 0, n_bl1 = 0, max_x1 = 0, max_y1 = 0, n_fs1 = 0, fs1_at = -1;
  int ls_a = -1, ls_b = -1, n_wide = 0, n_thaw = 0;
  logic        prev_ls0, applied_pe;
  logic [24:0] prev_out0;

  initial begin
    // Reset held with pix_en high: reset must win.
    repeat (3) @(negedge vga_clk);
    check("reset_dut0", {5'd0, act0}, 32'h0600_0000);
    check("reset_dut1", {5'd0, act1}, 32'h0000_0000);
    reset = 1'b0;

    // Full-speed run from reset.
    for (int n = 0; n < 28200; n++) begin
      @(negedge vga_clk);
      if (n == 0) begin
        check("first_fs0", {31'd0, if0.frame_start}, 32'd1);
        check("first_ls0", {31'd0, if0.line_start}, 32'd1);
      end
      if (n < 800 && !if0.HS) n_hs0_low++;
      if (n > 0 && if0.line_start && second_ls0 < 0) second_ls0 = n;
      if (!if0.VS) n_vs0_low++;
      if (if0.blank_n && first_bl0 < 0) begin
        first_bl0 = n;
        bl_x0 = int'(if0.x);
        bl_y0 = int'(if0.y);
      end
      if (n < 14 && if1.HS) n_hs1_hi++;
      if (n < 98 && if1.VS) n_vs1_hi++;
      if (n < 98 && if1.blank_n) n_bl1++;
      if (if1.blank_n && int'(if1.x) > max_x1) max_x1 = int'(if1.x);
      if (if1.blank_n && int'(if1.y) > max_y1) max_y1 = int'(if1.y);
      if (n < 196 && if1.frame_start) begin
        n_fs1++;
        if (n > 0) fs1_at = n;
      end
    end
    check("hs0_low_per_line", n_hs0_low, 96);
    check("ls0_period", second_ls0, 800);
    check("vs0_low_clocks", n_vs0_low, 1600);
    check("first_blank0_at", first_bl0, 35 * 800 + 144);
    check("first_blank0_x", bl_x0, 0);
    check("first_blank0_y", bl_y0, 0);
    check("hs1_high_per_line", n_hs1_hi, 2);
    check("vs1_high_per_frame", n_vs1_hi, 14);
    check("blank1_per_frame", n_bl1, 32);
    check("x1_max", max_x1, 7);
    check("y1_max", max_y1, 3);
    check("fs1_count_two_frames", n_fs1, 2);
    check("fs1_wrap_single_step", fs1_at, 98);

    // pix_en alternating on the default instance; random enable on the small one.
    prev_ls0   = if0.line_start;
    prev_out0  = act0[26:2];
    applied_pe = pe0;
    for (int n = 0; n < 3400; n++) begin
      pe0 = ~pe0;
      pe1 = 1'($urandom_range(0, 1));
      applied_pe = pe0;
      @(negedge vga_clk);
      if (if0.line_start && prev_ls0) n_wide++;
      if (!applied_pe && act0[26:2] !== prev_out0) n_thaw++;
      if (if0.line_start) begin
        if (ls_a < 0) ls_a = n;
        else if (ls_b < 0) ls_b = n;
      end
      prev_ls0  = if0.line_start;
      prev_out0 = act0[26:2];
    end
    check("ls0_period_half_rate", ls_b - ls_a, 1600);
    check("ls0_one_clock_wide", n_wide, 0);
    check("outputs_frozen_pe_low", n_thaw, 0);

    // Mid-frame reset pulse, then an idle clock, then the first pix_en.
    pe0   = 1'b1;
    pe1   = 1'b1;
    reset = 1'b1;
    @(negedge vga_clk);
    check("midframe_reset_dut0", {5'd0, act0}, 32'h0600_0000);
    check("midframe_reset_dut1", {5'd0, act1}, 32'h0000_0000);
    reset = 1'b0;
    pe0   = 1'b0;
    @(negedge vga_clk);
    check("no_fs_while_idle", {31'd0, if0.frame_start}, 32'd0);
    pe0 = 1'b1;
    @(negedge vga_clk);
    check("fs_after_reset", {31'd0, if0.frame_start}, 32'd1);
    check("ls_after_reset", {31'd0, if0.line_start}, 32'd1);
    repeat (200) @(negedge vga_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
